// File: rtl/alarm_pkg.sv
// ============================================================
// Package : alarm_pkg
// Alarm state encoding, buzzer modes, default thresholds and target rule.
// Rev     : 1.0
// ============================================================
`default_nettype none

package alarm_pkg;

  typedef enum logic [1:0] {
    ST_NORMAL  = 2'd0,
    ST_WARNING = 2'd1,
    ST_FIRE    = 2'd2
  } alarm_state_e;

  typedef enum logic [1:0] {
    BZ_OFF  = 2'd0,
    BZ_CONT = 2'd1,
    BZ_CAD  = 2'd2
  } buzz_mode_e;

  // Also used by the image generator to pick its status text.
  localparam logic [7:0] c_DEF_WARN_ON  = 8'd35;
  localparam logic [7:0] c_DEF_WARN_OFF = 8'd33;
  localparam logic [7:0] c_DEF_FIRE_ON  = 8'd50;
  localparam logic [7:0] c_DEF_FIRE_OFF = 8'd47;

  function automatic alarm_state_e alarm_target(
    input alarm_state_e s,
    input logic [7:0]   t,
    input logic [7:0]   warn_on,
    input logic [7:0]   warn_off,
    input logic [7:0]   fire_on,
    input logic [7:0]   fire_off
  );
    if (t >= fire_on)                      return ST_FIRE;
    if (s == ST_FIRE && t >= fire_off)     return ST_FIRE;
    if (t >= warn_on)                      return ST_WARNING;
    if (s != ST_NORMAL && t >= warn_off)   return ST_WARNING;
    return ST_NORMAL;
  endfunction

endpackage

`default_nettype wire

// File: rtl/buzzer_tone_gen.sv
// ============================================================
// Module : buzzer_tone_gen
// Square-wave tone divider with optional on/off cadence gating.
// Rev    : 1.0
// ============================================================
`default_nettype none

module buzzer_tone_gen
  import alarm_pkg::*;
#(
  parameter int TONE_HALF_CYC = 25000,
  parameter int BEEP_ON_CYC   = 25000000,
  parameter int BEEP_OFF_CYC  = 25000000
) (
  input  logic       clk,
  input  logic       rst,
  input  buzz_mode_e mode,
  input  logic       restart,
  output logic       buzzer
);

  localparam int c_TONE_W = $clog2(TONE_HALF_CYC + 1);
  localparam int c_CAD_W  = $clog2(BEEP_ON_CYC + BEEP_OFF_CYC + 1);

  localparam logic [c_TONE_W-1:0] c_TONE_LAST = c_TONE_W'(TONE_HALF_CYC - 1);
  localparam logic [c_CAD_W-1:0]  c_CAD_LAST  = c_CAD_W'(BEEP_ON_CYC + BEEP_OFF_CYC - 1);
  localparam logic [c_CAD_W-1:0]  c_CAD_ON    = c_CAD_W'(BEEP_ON_CYC);

  logic [c_TONE_W-1:0] r_tone_cnt;
  logic [c_CAD_W-1:0]  r_cad_cnt;
  logic                r_tone;
  logic                r_buzzer;

  logic                w_tone_wrap;
  logic [c_TONE_W-1:0] w_tone_cnt_nxt;
  logic                w_tone_nxt;
  logic [c_CAD_W-1:0]  w_cad_cnt_nxt;
  logic                w_cad_on;

  always_comb begin
    w_tone_wrap    = (r_tone_cnt == c_TONE_LAST);
    w_tone_cnt_nxt = w_tone_wrap ? '0 : r_tone_cnt + c_TONE_W'(1);
    w_tone_nxt     = r_tone ^ w_tone_wrap;
    w_cad_cnt_nxt  = (r_cad_cnt == c_CAD_LAST) ? '0 : r_cad_cnt + c_CAD_W'(1);
    w_cad_on       = (w_cad_cnt_nxt < c_CAD_ON);
  end

  // Silence or restart parks both counters so a new tone always begins
  // with a full low half-period at the start of the cadence on-phase.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tone_cnt <= '0;
      r_cad_cnt  <= '0;
      r_tone     <= 1'b0;
      r_buzzer   <= 1'b0;
    end else if (restart || mode == BZ_OFF) begin
      r_tone_cnt <= '0;
      r_cad_cnt  <= '0;
      r_tone     <= 1'b0;
      r_buzzer   <= 1'b0;
    end else begin
      r_tone_cnt <= w_tone_cnt_nxt;
      r_cad_cnt  <= w_cad_cnt_nxt;
      r_tone     <= w_tone_nxt;
      case (mode)
        BZ_CONT: r_buzzer <= w_tone_nxt;
        BZ_CAD:  r_buzzer <= w_tone_nxt & w_cad_on;
        default: r_buzzer <= 1'b0;
      endcase
    end
  end

  assign buzzer = r_buzzer;

endmodule

`default_nettype wire

// File: rtl/temp_alarm_ctrl.sv
// ============================================================
// Module : temp_alarm_ctrl
// Temperature alarm with hysteresis, N-sample persistence, timed mute.
// Rev    : 1.0
// ============================================================
`default_nettype none

module temp_alarm_ctrl
  import alarm_pkg::*;
#(
  parameter logic [7:0] WARN_ON       = c_DEF_WARN_ON,
  parameter logic [7:0] WARN_OFF      = c_DEF_WARN_OFF,
  parameter logic [7:0] FIRE_ON       = c_DEF_FIRE_ON,
  parameter logic [7:0] FIRE_OFF      = c_DEF_FIRE_OFF,
  parameter int         PERSIST_N     = 3,
  parameter int         TONE_HALF_CYC = 25000,
  parameter int         BEEP_ON_CYC   = 25000000,
  parameter int         BEEP_OFF_CYC  = 25000000,
  parameter int         MUTE_CYC      = 1000000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tmp,
  input  logic       tmp_valid,
  input  logic       mute_req,
  output logic [1:0] alarm_state,
  output logic       is_warning,
  output logic       is_fire,
  output logic       muted,
  output logic       buzzer
);

  localparam int c_CNT_W  = $clog2(PERSIST_N + 1);
  localparam int c_MUTE_W = $clog2(MUTE_CYC + 1);

  localparam logic [c_CNT_W-1:0]  c_PERSIST   = c_CNT_W'(PERSIST_N);
  localparam logic [c_MUTE_W-1:0] c_MUTE_LOAD = c_MUTE_W'(MUTE_CYC);

  alarm_state_e        r_state;
  alarm_state_e        r_cand;
  logic [c_CNT_W-1:0]  r_cnt;
  logic                r_is_warning;
  logic                r_is_fire;
  logic                r_muted;
  logic [c_MUTE_W-1:0] r_mute_cnt;
  logic                r_restart;

  alarm_state_e        w_target;
  alarm_state_e        w_nxt_state;
  alarm_state_e        w_nxt_cand;
  logic [c_CNT_W-1:0]  w_nxt_cnt;
  logic [c_CNT_W-1:0]  w_cnt_inc;
  logic                w_state_chg;
  logic                w_nxt_muted;
  logic [c_MUTE_W-1:0] w_nxt_mute_cnt;
  logic                w_mute_expire;
  buzz_mode_e          w_mode;

  assign w_target = alarm_target(r_state, tmp, WARN_ON, WARN_OFF, FIRE_ON, FIRE_OFF);

  // A target differing from the last candidate starts a fresh run of one.
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_cand  = r_cand;
    w_nxt_cnt   = r_cnt;
    w_cnt_inc   = ((w_target == r_cand) ? r_cnt : '0) + c_CNT_W'(1);
    if (tmp_valid) begin
      if (w_target == r_state) begin
        w_nxt_cnt = '0;
      end else begin
        w_nxt_cand = w_target;
        if (w_cnt_inc >= c_PERSIST) begin
          w_nxt_state = w_target;
          w_nxt_cnt   = '0;
        end else begin
          w_nxt_cnt = w_cnt_inc;
        end
      end
    end
  end

  assign w_state_chg = (w_nxt_state != r_state);

  // Entering FIRE or NORMAL always unmutes, even against a simultaneous request.
  always_comb begin
    w_nxt_muted    = r_muted;
    w_nxt_mute_cnt = r_mute_cnt;
    w_mute_expire  = 1'b0;
    if (w_state_chg && (w_nxt_state == ST_FIRE || w_nxt_state == ST_NORMAL)) begin
      w_nxt_muted    = 1'b0;
      w_nxt_mute_cnt = '0;
    end else if (mute_req && r_state != ST_NORMAL) begin
      w_nxt_muted    = 1'b1;
      w_nxt_mute_cnt = c_MUTE_LOAD;
    end else if (r_muted) begin
      if (r_mute_cnt == c_MUTE_W'(1)) begin
        w_nxt_muted    = 1'b0;
        w_nxt_mute_cnt = '0;
        w_mute_expire  = 1'b1;
      end else begin
        w_nxt_mute_cnt = r_mute_cnt - c_MUTE_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_NORMAL;
      r_cand       <= ST_NORMAL;
      r_cnt        <= '0;
      r_is_warning <= 1'b0;
      r_is_fire    <= 1'b0;
      r_muted      <= 1'b0;
      r_mute_cnt   <= '0;
      r_restart    <= 1'b0;
    end else begin
      r_state      <= w_nxt_state;
      r_cand       <= w_nxt_cand;
      r_cnt        <= w_nxt_cnt;
      r_is_warning <= (w_nxt_state == ST_WARNING);
      r_is_fire    <= (w_nxt_state == ST_FIRE);
      r_muted      <= w_nxt_muted;
      r_mute_cnt   <= w_nxt_mute_cnt;
      r_restart    <= w_state_chg | w_mute_expire;
    end
  end

  always_comb begin
    w_mode = BZ_OFF;
    if (!r_muted) begin
      case (r_state)
        ST_FIRE:    w_mode = BZ_CONT;
        ST_WARNING: w_mode = BZ_CAD;
        default:    w_mode = BZ_OFF;
      endcase
    end
  end

  buzzer_tone_gen #(
    .TONE_HALF_CYC (TONE_HALF_CYC),
    .BEEP_ON_CYC   (BEEP_ON_CYC),
    .BEEP_OFF_CYC  (BEEP_OFF_CYC)
  ) u_tone (
    .clk     (clk),
    .rst     (rst),
    .mode    (w_mode),
    .restart (r_restart),
    .buzzer  (buzzer)
  );

  assign alarm_state = r_state;
  assign is_warning  = r_is_warning;
  assign is_fire     = r_is_fire;
  assign muted       = r_muted;

endmodule

`default_nettype wire

// File: tb/tb_temp_alarm_ctrl.sv
// ============================================================
// Module : tb_temp_alarm_ctrl
// Directed self-checking bench for temp_alarm_ctrl.
// Rev    : 1.0
// ============================================================
`default_nettype none

module tb_temp_alarm_ctrl;

  logic       clk;
  logic       rst;
  logic [7:0] tmp;
  logic       tmp_valid;
  logic       mute_req;
  logic [1:0] alarm_state;
  logic       is_warning;
  logic       is_fire;
  logic       muted;
  logic       buzzer;

  int n_tests;
  int n_fail;
  logic s [0:87];

  temp_alarm_ctrl #(
    .PERSIST_N     (3),
    .TONE_HALF_CYC (4),
    .BEEP_ON_CYC   (40),
    .BEEP_OFF_CYC  (40),
    .MUTE_CYC      (100)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .tmp         (tmp),
    .tmp_valid   (tmp_valid),
    .mute_req    (mute_req),
    .alarm_state (alarm_state),
    .is_warning  (is_warning),
    .is_fire     (is_fire),
    .muted       (muted),
    .buzzer      (buzzer)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic send(input logic [7:0] t, input logic m);
    tmp       = t;
    tmp_valid = 1'b1;
    mute_req  = m;
    @(negedge clk);
    tmp_valid = 1'b0;
    mute_req  = 1'b0;
  endtask

  task automatic send_n(input logic [7:0] t, input int n);
    for (int i = 0; i < n; i++) send(t, 1'b0);
  endtask

  task automatic pulse_mute();
    mute_req = 1'b1;
    @(negedge clk);
    mute_req = 1'b0;
  endtask

  // Tone restart: counters clear one edge after the change, then 4 low cycles.
  task automatic wait_rise(input string tag);
    int k;
    k = 0;
    while (!buzzer && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk(tag, k, 5);
  endtask

  task automatic capture(input int n);
    for (int i = 0; i < n; i++) begin
      s[i] = buzzer;
      @(negedge clk);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_state"}, alarm_state, 0);
    chk({tag, "_warn"},  is_warning, 0);
    chk({tag, "_fire"},  is_fire, 0);
    chk({tag, "_muted"}, muted, 0);
    chk({tag, "_buzz"},  buzzer, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int ones;
    int n;
    n_tests   = 0;
    n_fail    = 0;
    rst       = 1'b1;
    tmp       = 8'd0;
    tmp_valid = 1'b0;
    mute_req  = 1'b0;
    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    send_n(8'd20, 5);
    chk("t1_normal", alarm_state, 0);
    chk("t1_buzz", buzzer, 0);

    // Interrupted run: the NORMAL sample clears the count.
    send(8'd36, 0); send(8'd36, 0); send(8'd30, 0); send(8'd36, 0);
    chk("t2_interrupted", alarm_state, 0);
    send(8'd20, 0);
    send_n(8'd36, 2);
    chk("t2_two_strobes", is_warning, 0);
    send(8'd36, 0);
    chk("t2_warn", is_warning, 1);
    chk("t2_state", alarm_state, 1);

    send_n(8'd34, 5);
    chk("t3_hyst_hold", alarm_state, 1);
    send_n(8'd32, 2);
    chk("t3_two_low", alarm_state, 1);
    send(8'd32, 0);
    chk("t3_normal", alarm_state, 0);
    chk("t3_warn_clr", is_warning, 0);
    @(negedge clk);
    chk("t3_buzz_off", buzzer, 0);

    send_n(8'd55, 3);
    chk("t4_fire", is_fire, 1);
    chk("t4_state", alarm_state, 2);
    wait_rise("t4_fire_tone_start");
    capture(16);
    ones = 0;
    for (int i = 0; i < 16; i++) ones += int'(s[i]);
    chk("t4_fire_duty", ones, 8);
    chk("t4_fire_low", s[4], 0);
    chk("t4_fire_high", s[8], 1);

    send_n(8'd48, 3);
    chk("t4_fire_hold", alarm_state, 2);
    send_n(8'd46, 3);
    chk("t4_fire_to_warn", alarm_state, 1);
    wait_rise("t4_warn_tone_start");
    capture(88);
    ones = 0;
    for (int i = 0; i < 36; i++) ones += int'(s[i]);
    chk("t4_cad_on_ones", ones, 20);
    ones = 0;
    for (int i = 36; i < 80; i++) ones += int'(s[i]);
    chk("t4_cad_off_ones", ones, 0);
    chk("t4_cad_resume", s[80], 1);

    pulse_mute();
    chk("t5_muted", muted, 1);
    n = 0;
    ones = 0;
    while (muted && n < 300) begin
      if (n > 0) ones += int'(buzzer);
      n++;
      @(negedge clk);
    end
    chk("t5_mute_len", n, 100);
    chk("t5_mute_silent", ones, 0);
    wait_rise("t5_release_phase");

    pulse_mute();
    chk("t5_muted_again", muted, 1);
    send_n(8'd55, 2);
    chk("t5_still_muted", muted, 1);
    send(8'd55, 0);
    chk("t5_fire_entry", is_fire, 1);
    chk("t5_fire_unmute", muted, 0);
    wait_rise("t5_fire_tone");

    send_n(8'd46, 3);
    chk("t5_back_warn", alarm_state, 1);
    send_n(8'd55, 2);
    send(8'd55, 1);
    chk("t5_same_cycle_fire", is_fire, 1);
    chk("t5_same_cycle_unmute", muted, 0);

    send_n(8'd20, 3);
    chk("t5_normal", alarm_state, 0);
    pulse_mute();
    chk("t5_normal_mute_ignored", muted, 0);

    send_n(8'd55, 3);
    chk("t6_fire", is_fire, 1);
    repeat (7) @(negedge clk);
    #2 rst = 1'b1;
    #1 chk_all_zero("t6_async");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("t6_normal", alarm_state, 0);
    send_n(8'd55, 2);
    chk("t6_two_strobes", is_fire, 0);
    send(8'd55, 0);
    chk("t6_fire_again", is_fire, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
